// File: rtl/seg7_card_readback_if.sv
// Segment readback bus: observed seg7 drive in, decoded card event out (valid/ready).
interface seg7_card_readback_if;
    logic [6:0] seg7;
    logic [3:0] out_card;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;

    modport master (
        input  seg7,
        input  out_ready,
        output out_card,
        output out_err,
        output out_valid,
        output overrun
    );

    modport slave (
        output seg7,
        output out_ready,
        input  out_card,
        input  out_err,
        input  out_valid,
        input  overrun
    );
endinterface

// File: rtl/seg7_card_readback.sv
// Decodes a debounced active-low seg7 drive into a card code; latency STABLE_CYCLES+1 edges after sampling.
// Single-entry output: an event arriving while full is dropped and flagged in sticky overrun.
// Optional macro SEG7_READBACK_BLANK_REPORT_EN: report stable blank (7'h7F) as card 0.
module seg7_card_readback #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_card_readback_if.master  bus
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [0:0] SETTLE = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [6:0] BLANK = 7'h7F;

    logic [6:0]    seg7_q, seg7_d;
    logic [6:0]    cand_q, cand_d;
    logic [6:0]    last_rep_q, last_rep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    out_card_q, out_card_d;
    logic          out_err_q, out_err_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic          evt;
    logic [4:0]    dec;

    // Returns {err, card}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h7F:   r = {1'b0, 4'd0};
            7'h08:   r = {1'b0, 4'd1};
            7'h24:   r = {1'b0, 4'd2};
            7'h30:   r = {1'b0, 4'd3};
            7'h19:   r = {1'b0, 4'd4};
            7'h12:   r = {1'b0, 4'd5};
            7'h02:   r = {1'b0, 4'd6};
            7'h78:   r = {1'b0, 4'd7};
            7'h00:   r = {1'b0, 4'd8};
            7'h10:   r = {1'b0, 4'd9};
            7'h40:   r = {1'b0, 4'd10};
            7'h61:   r = {1'b0, 4'd11};
            7'h18:   r = {1'b0, 4'd12};
            7'h09:   r = {1'b0, 4'd13};
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    always_comb begin
        seg7_d      = bus.seg7;
        cand_d      = cand_q;
        last_rep_d  = last_rep_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        out_card_d  = out_card_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        evt         = 1'b0;
        dec         = decode(cand_q);

        if (seg7_q != cand_q) begin
            cand_d  = seg7_q;
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q < CNT_LAST) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                state_d    = LOCKED;
                last_rep_d = cand_q;
`ifdef SEG7_READBACK_BLANK_REPORT_EN
                evt        = (cand_q != last_rep_q);
`else
                // Blank still updates last_rep so the next card is reported afresh.
                evt        = (cand_q != last_rep_q) && (cand_q != BLANK);
`endif
            end
        end

        if (evt) begin
            if (!out_valid_q || bus.out_ready) begin
                out_card_d  = dec[3:0];
                out_err_d   = dec[4];
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg7_q      <= BLANK;
            cand_q      <= BLANK;
            last_rep_q  <= BLANK;
            cnt_q       <= '0;
            state_q     <= LOCKED;
            out_card_q  <= 4'd0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            seg7_q      <= seg7_d;
            cand_q      <= cand_d;
            last_rep_q  <= last_rep_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            out_card_q  <= out_card_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_card  = out_card_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_card_readback.sv
// Scoreboard bench for seg7_card_readback: expected {err,card} queued at drive, popped on each transfer.
module tb_seg7_card_readback;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   d_cyc;
    logic [4:0] exp_q[$];

    seg7_card_readback_if bus ();

    seg7_card_readback #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] p);
        @(posedge clk);
        #1;
        bus.seg7 = p;
        d_cyc    = cyc;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transfer happens on the next rising edge when valid and ready are seen here.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            check("evt_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("evt_payload", {bus.out_err, bus.out_card}, e);
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        d_cyc         = 0;
        reset         = 1'b1;
        bus.seg7      = 7'h7F;
        bus.out_ready = 1'b1;
        #12;
        check("rst_valid",   bus.out_valid, 0);
        check("rst_card",    bus.out_card,  0);
        check("rst_err",     bus.out_err,   0);
        check("rst_overrun", bus.overrun,   0);
        reset = 1'b0;
        wait_cyc(3);

        // Single card with latency measurement
        drive(7'h30);
        exp_q.push_back({1'b0, 4'd3});
        begin
            int lat;
            bit seen;
            lat  = -1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    seen = 1'b1;
                    lat  = cyc - d_cyc;
                end
            end
            check("t1_latency", lat, 6);
        end
        wait_cyc(15);
        check("t1_drained", exp_q.size(), 0);
        check("t1_valid_low", bus.out_valid, 0);

        // Glitch rejection
        drive(7'h09);
        exp_q.push_back({1'b0, 4'd13});
        wait_cyc(12);
        drive(7'h00);
        repeat (2) @(posedge clk);
        drive(7'h09);
        wait_cyc(15);
        check("t2_drained", exp_q.size(), 0);
        check("t2_valid_low", bus.out_valid, 0);

        // Invalid glyph
        drive(7'h55);
        exp_q.push_back({1'b1, 4'hF});
        wait_cyc(12);
        check("t3_drained", exp_q.size(), 0);

        // Backpressure and overrun; second event dropped
        bus.out_ready = 1'b0;
        drive(7'h24);
        exp_q.push_back({1'b0, 4'd2});
        wait_cyc(12);
        check("t4_held_valid", bus.out_valid, 1);
        check("t4_held_card",  bus.out_card,  2);
        check("t4_no_ovr_yet", bus.overrun,   0);
        drive(7'h12);
        wait_cyc(12);
        check("t4_overrun",   bus.overrun,  1);
        check("t4_card_kept", bus.out_card, 2);
        check("t4_err_kept",  bus.out_err,  0);
        bus.out_ready = 1'b1;
        wait_cyc(3);
        check("t4_drained",   exp_q.size(), 0);
        check("t4_valid_low", bus.out_valid, 0);

        // Blank handling
        drive(7'h78);
        exp_q.push_back({1'b0, 4'd7});
        wait_cyc(12);
        drive(7'h7F);
`ifdef SEG7_READBACK_BLANK_REPORT_EN
        exp_q.push_back({1'b0, 4'd0});
`endif
        wait_cyc(12);
        check("t5_blank_drained", exp_q.size(), 0);
        drive(7'h78);
        exp_q.push_back({1'b0, 4'd7});
        wait_cyc(12);
        check("t5_drained", exp_q.size(), 0);

        // Async reset with unread output and overrun set; these events are discarded
        bus.out_ready = 1'b0;
        drive(7'h30);
        wait_cyc(12);
        drive(7'h19);
        wait_cyc(12);
        check("t6_pre_valid",   bus.out_valid, 1);
        check("t6_pre_overrun", bus.overrun,   1);
        @(negedge clk);
        #1;
        reset    = 1'b1;
        bus.seg7 = 7'h7F;
        #1;
        check("t6_valid",   bus.out_valid, 0);
        check("t6_card",    bus.out_card,  0);
        check("t6_err",     bus.out_err,   0);
        check("t6_overrun", bus.overrun,   0);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        wait_cyc(10);
        check("t6_post_valid", bus.out_valid, 0);

        // Normal operation after reset
        drive(7'h30);
        exp_q.push_back({1'b0, 4'd3});
        wait_cyc(12);
        check("t7_drained", exp_q.size(), 0);
        check("t7_overrun", bus.overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
